// File: rtl/pagerank_pkg.sv
// Shared types and widths for the PageRank gather scheduler.
package pagerank_pkg;

    localparam int unsigned PR_DATA_W = 64;
    localparam int unsigned PR_ID_W   = 32;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StScatter,
        StDrain,
        StComplete,
        StWaitGather
    } fsm_state_t;

    typedef struct packed {
        logic [PR_DATA_W-1:0] data;
        logic [PR_ID_W-1:0]   dest;
    } pr_update_t;

endpackage

// File: rtl/pagerank_gather_scheduler_if.sv
// Scatter-thread request bundle: threads drive updates, the scheduler returns grants.
interface pagerank_gather_scheduler_if
    import pagerank_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 4
);

    logic [NUM_THREADS-1:0]                req_valid;
    logic [NUM_THREADS-1:0]                req_ready;
    logic [NUM_THREADS-1:0]                thread_done;
    logic [NUM_THREADS-1:0][PR_DATA_W-1:0] req_data;
    logic [NUM_THREADS-1:0][PR_ID_W-1:0]   req_dest;

    modport master (
        output req_valid,
        output req_data,
        output req_dest,
        output thread_done,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_dest,
        input  thread_done,
        output req_ready
    );

endinterface

// File: rtl/pagerank_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr.
module pagerank_rr_arbiter #(
    parameter int unsigned NUM_THREADS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_THREADS-1:0] req,
    input  logic                   advance,
    output logic [NUM_THREADS-1:0] grant
);

    localparam int unsigned PtrW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    logic [PtrW-1:0] rr_ptr;
    logic [PtrW-1:0] grant_idx;
    logic [PtrW-1:0] cand;
    logic            found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            cand = PtrW'((32'(rr_ptr) + i) % NUM_THREADS);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (32'(grant_idx) + 32'd1 == NUM_THREADS) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/pagerank_gather_scheduler.sv
// Sequences one PageRank gather iteration and funnels thread updates into the accumulator.
module pagerank_gather_scheduler
    import pagerank_pkg::*;
#(
    parameter int unsigned NUM_THREADS    = 4,
    parameter int unsigned NODES_IN_GRAPH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    pagerank_gather_scheduler_if.slave thr,
    output logic                       acc_clear,
    output logic [PR_DATA_W-1:0]       page_rank_scatter,
    output logic [PR_ID_W-1:0]         dest_id,
    output logic                       pagerank_ready,
    output logic                       scatter_operation_complete,
    input  logic                       gather_operation_complete,
    output logic                       busy,
    output logic                       iter_done,
    output logic [31:0]                update_count,
    output logic                       range_error
);

    fsm_state_t             state;
    logic [NUM_THREADS-1:0] arb_req;
    logic [NUM_THREADS-1:0] grant;
    logic                   xfer;
    logic                   in_range;
    logic                   scatter_exit;
    pr_update_t             sel;

    assign arb_req = (state == StScatter) ? thr.req_valid : '0;

    pagerank_rr_arbiter #(
        .NUM_THREADS(NUM_THREADS)
    ) u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    (arb_req),
        .advance(xfer),
        .grant  (grant)
    );

    assign thr.req_ready = grant;
    assign xfer          = |grant;
    assign in_range      = sel.dest < NODES_IN_GRAPH;
    // Leave once every thread is done and any valid this cycle is the one being granted.
    assign scatter_exit  = (&thr.thread_done) && ((thr.req_valid & ~grant) == '0);
    assign busy          = (state != StIdle);
    assign iter_done     = (state == StWaitGather) && gather_operation_complete;

    always_comb begin
        sel = '0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            if (grant[t]) begin
                sel.data = thr.req_data[t];
                sel.dest = thr.req_dest[t];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                      <= StIdle;
            acc_clear                  <= 1'b0;
            scatter_operation_complete <= 1'b0;
            pagerank_ready             <= 1'b0;
            page_rank_scatter          <= '0;
            dest_id                    <= '0;
            update_count               <= '0;
            range_error                <= 1'b0;
        end else begin
            acc_clear                  <= 1'b0;
            scatter_operation_complete <= 1'b0;
            pagerank_ready             <= 1'b0;

            // Out-of-range destinations are consumed but never reach the accumulator.
            if (xfer) begin
                if (in_range) begin
                    pagerank_ready    <= 1'b1;
                    page_rank_scatter <= sel.data;
                    dest_id           <= sel.dest;
                    update_count      <= update_count + 32'd1;
                end else begin
                    range_error <= 1'b1;
                end
            end

            unique case (state)
                StIdle: begin
                    if (start) begin
                        state        <= StClear;
                        acc_clear    <= 1'b1;
                        update_count <= '0;
                        range_error  <= 1'b0;
                    end
                end
                StClear: state <= StScatter;
                StScatter: begin
                    if (scatter_exit) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    state                      <= StComplete;
                    scatter_operation_complete <= 1'b1;
                end
                StComplete: state <= StWaitGather;
                StWaitGather: begin
                    if (gather_operation_complete) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pagerank_gather_scheduler.sv
// Bench for pagerank_gather_scheduler: vector table for arbitration plus scoreboarded updates.
module tb_pagerank_gather_scheduler;
    import pagerank_pkg::*;

    localparam int unsigned NT    = 4;
    localparam int unsigned NODES = 32;
    localparam int unsigned NVEC  = 11;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        gather_operation_complete;
    logic        acc_clear;
    logic [63:0] page_rank_scatter;
    logic [31:0] dest_id;
    logic        pagerank_ready;
    logic        scatter_operation_complete;
    logic        busy;
    logic        iter_done;
    logic [31:0] update_count;
    logic        range_error;

    pagerank_gather_scheduler_if #(.NUM_THREADS(NT)) thr ();

    pagerank_gather_scheduler #(
        .NUM_THREADS   (NT),
        .NODES_IN_GRAPH(NODES)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .start                     (start),
        .thr                       (thr),
        .acc_clear                 (acc_clear),
        .page_rank_scatter         (page_rank_scatter),
        .dest_id                   (dest_id),
        .pagerank_ready            (pagerank_ready),
        .scatter_operation_complete(scatter_operation_complete),
        .gather_operation_complete (gather_operation_complete),
        .busy                      (busy),
        .iter_done                 (iter_done),
        .update_count              (update_count),
        .range_error               (range_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] done;
        logic [3:0] oor;
        logic [3:0] exp_ready;
    } vec_t;

    vec_t       vecs [NVEC];
    pr_update_t exp_q[$];
    pr_update_t mon_e;
    int         total = 0;
    int         bad   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Every accumulator strobe must match the oldest expected update.
    always @(negedge clock) begin
        if (pagerank_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected actual=%0h/%0h required=none", page_rank_scatter,
                         dest_id);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_data", page_rank_scatter, mon_e.data);
                chk("sb_dest", 64'(dest_id), 64'(mon_e.dest));
            end
        end
    end

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        next();
        start = 1'b0;
        @(negedge clock);
        chk("clear_pulse", 64'(acc_clear), 64'd1);
        chk("clear_busy", 64'(busy), 64'd1);
        next();
    endtask

    task automatic hand_xfer(input int t, input logic [63:0] d, input logic [31:0] dst);
        thr.req_valid   = 4'(1 << t);
        thr.req_data[t] = d;
        thr.req_dest[t] = dst;
        @(negedge clock);
        chk("hand_grant", 64'(thr.req_ready), 64'(1 << t));
        exp_q.push_back('{data: d, dest: dst});
        next();
    endtask

    task automatic apply_vec(input int i);
        for (int t = 0; t < NT; t++) begin
            thr.req_data[t] = 64'(i * 16 + t);
            thr.req_dest[t] = vecs[i].oor[t] ? NODES : 32'((i * 4 + t) % NODES);
        end
        thr.req_valid   = vecs[i].valid;
        thr.thread_done = vecs[i].done;
        @(negedge clock);
        chk($sformatf("grant_v%0d", i), 64'(thr.req_ready), 64'(vecs[i].exp_ready));
        for (int t = 0; t < NT; t++) begin
            if (vecs[i].exp_ready[t] && !vecs[i].oor[t]) begin
                exp_q.push_back('{data: thr.req_data[t], dest: thr.req_dest[t]});
            end
        end
        next();
    endtask

    initial begin
        // {valid, done, out-of-range, expected grant}; rr pointer starts at 0
        vecs[0]  = '{4'hF, 4'h0, 4'h0, 4'h1};
        vecs[1]  = '{4'hF, 4'h0, 4'h0, 4'h2};
        vecs[2]  = '{4'hF, 4'h0, 4'h0, 4'h4};
        vecs[3]  = '{4'hF, 4'h0, 4'h0, 4'h8};
        vecs[4]  = '{4'hF, 4'h0, 4'h0, 4'h1};
        vecs[5]  = '{4'hF, 4'h0, 4'h0, 4'h2};
        vecs[6]  = '{4'hF, 4'h0, 4'h0, 4'h4};
        vecs[7]  = '{4'hF, 4'h0, 4'h0, 4'h8};
        vecs[8]  = '{4'h4, 4'h0, 4'h4, 4'h4};
        vecs[9]  = '{4'h3, 4'hD, 4'h0, 4'h1};
        vecs[10] = '{4'h2, 4'hF, 4'h0, 4'h2};

        reset = 1'b1;
        start = 1'b0;
        gather_operation_complete = 1'b0;
        thr.req_valid   = '0;
        thr.thread_done = '0;
        thr.req_data    = '0;
        thr.req_dest    = '0;
        repeat (2) next();
        @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_prr", 64'(pagerank_ready), 64'd0);
        chk("rst_count", 64'(update_count), 64'd0);
        chk("rst_rerr", 64'(range_error), 64'd0);
        chk("rst_data", page_rank_scatter, 64'd0);
        chk("rst_dest", 64'(dest_id), 64'd0);
        chk("rst_clear", 64'(acc_clear), 64'd0);
        next();
        reset = 1'b0;

        // Single thread: three updates then done
        thr.thread_done = 4'hE;
        do_start();
        hand_xfer(0, 64'd10, 32'd3);
        hand_xfer(0, 64'd20, 32'd5);
        hand_xfer(0, 64'd30, 32'd3);
        thr.req_valid   = '0;
        thr.thread_done = 4'hF;
        @(negedge clock);
        chk("a_last_ready", 64'(thr.req_ready), 64'd0);
        next();
        @(negedge clock);
        chk("a_drain_cmpl", 64'(scatter_operation_complete), 64'd0);
        next();
        @(negedge clock);
        chk("a_cmpl", 64'(scatter_operation_complete), 64'd1);
        chk("a_cmpl_prr", 64'(pagerank_ready), 64'd0);
        next();
        gather_operation_complete = 1'b1;
        @(negedge clock);
        chk("a_iter_done", 64'(iter_done), 64'd1);
        next();
        gather_operation_complete = 1'b0;
        @(negedge clock);
        chk("a_idle", 64'(busy), 64'd0);
        chk("a_count", 64'(update_count), 64'd3);
        chk("a_sb_empty", 64'(exp_q.size()), 64'd0);
        next();

        // Reset in the middle of a scatter stream
        thr.thread_done = 4'h0;
        do_start();
        hand_xfer(3, 64'hAB, 32'd7);
        reset = 1'b1;
        next();
        reset = 1'b0;
        @(negedge clock);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_prr", 64'(pagerank_ready), 64'd0);
        chk("mr_count", 64'(update_count), 64'd0);
        chk("mr_ready", 64'(thr.req_ready), 64'd0);
        chk("mr_sb_empty", 64'(exp_q.size()), 64'd0);
        thr.req_valid = '0;
        next();

        // Table: round-robin, out-of-range drop, valid together with done
        do_start();
        for (int i = 0; i < NVEC; i++) begin
            apply_vec(i);
        end
        @(negedge clock);
        chk("t_drain_ready", 64'(thr.req_ready), 64'd0);
        chk("t_drain_cmpl", 64'(scatter_operation_complete), 64'd0);
        chk("t_rerr", 64'(range_error), 64'd1);
        chk("t_count", 64'(update_count), 64'd10);
        thr.req_valid = '0;
        next();
        @(negedge clock);
        chk("t_cmpl", 64'(scatter_operation_complete), 64'd1);
        next();
        start = 1'b1;
        @(negedge clock);
        chk("w_start_busy", 64'(busy), 64'd1);
        next();
        start = 1'b0;
        @(negedge clock);
        chk("w_start_ignored", 64'(acc_clear), 64'd0);
        for (int c = 0; c < 9; c++) begin
            chk("w_hold_busy", 64'(busy), 64'd1);
            chk("w_hold_iter", 64'(iter_done), 64'd0);
            next();
            @(negedge clock);
        end
        next();
        gather_operation_complete = 1'b1;
        @(negedge clock);
        chk("w_iter_done", 64'(iter_done), 64'd1);
        next();
        gather_operation_complete = 1'b0;
        @(negedge clock);
        chk("w_idle", 64'(busy), 64'd0);
        chk("w_rerr_sticky", 64'(range_error), 64'd1);
        chk("w_sb_empty", 64'(exp_q.size()), 64'd0);
        next();

        // Empty iteration: timing from start and clearing of range_error
        thr.thread_done = 4'hF;
        start = 1'b1;
        next();
        start = 1'b0;
        @(negedge clock);
        chk("e_clear", 64'(acc_clear), 64'd1);
        chk("e_rerr_cleared", 64'(range_error), 64'd0);
        chk("e_count_cleared", 64'(update_count), 64'd0);
        next();
        @(negedge clock);
        chk("e_scatter_clear", 64'(acc_clear), 64'd0);
        chk("e_scatter_cmpl", 64'(scatter_operation_complete), 64'd0);
        next();
        @(negedge clock);
        chk("e_drain_cmpl", 64'(scatter_operation_complete), 64'd0);
        chk("e_drain_busy", 64'(busy), 64'd1);
        next();
        @(negedge clock);
        chk("e_cmpl", 64'(scatter_operation_complete), 64'd1);
        next();
        gather_operation_complete = 1'b1;
        @(negedge clock);
        chk("e_iter_done", 64'(iter_done), 64'd1);
        next();
        gather_operation_complete = 1'b0;
        @(negedge clock);
        chk("e_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
